conv_encoder: RTL and testbench

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/viterbi_pkg.sv | 8 +
 rtl/conv_enc_core.sv | 16 +
 rtl/conv_encoder.sv | 68 ++++++
 tb/tb_conv_encoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared K=3 rate-1/2 code constants (K, G0, G1, NUM_STATES) and the encoder FSM state encoding
package viterbi_pkg;
    localparam int K = 3;
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;
    localparam int NUM_STATES = 4;
    typedef enum logic [1:0] {IDLE, DATA, TAIL1, TAIL2} enc_state_e;
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational trellis step; inputs state={s1,s0} and bit u, outputs next_state={u,s1} and code bits c0 (G0), c1 (G1)
module conv_enc_core
    import viterbi_pkg::*;
(
    input  logic [1:0] state,
    input  logic       u,
    output logic [1:0] next_state,
    output logic       c0,
    output logic       c1
);
    logic [K-1:0] r;
    assign r = {u, state};
    assign c0 = ^(r & G0);
    assign c1 = ^(r & G1);
    assign next_state = {u, state[1]};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: framed K=3 rate-1/2 encoder; bits in via in_valid_i/in_bit_i/in_last_i/in_ready_o, symbols out via sym_valid_o/sym_o/sym_last_o/sym_ready_i, plus busy_o and sym_cnt_o frame status
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int TAIL_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    input  logic             in_bit_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             sym_valid_o,
    output logic [1:0]       sym_o,
    output logic             sym_last_o,
    input  logic             sym_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] sym_cnt_o
);
    enc_state_e st;
    logic [1:0] s, s_nxt;
    logic c0, c1, load_ok, tail_st, accept, tail_step, u, cons, frame_end, clr_pend;
    assign load_ok = !sym_valid_o || sym_ready_i;
    assign tail_st = (st == TAIL1) || (st == TAIL2);
    assign in_ready_o = load_ok && !tail_st;
    assign accept = in_valid_i && in_ready_o;
    assign tail_step = load_ok && tail_st;
    assign u = accept && in_bit_i;
    assign cons = sym_valid_o && sym_ready_i;
    // the symbol that closes the frame: TAIL2 with a tail, the last data bit without one
    assign frame_end = (tail_step && st == TAIL2) || (accept && in_last_i && TAIL_EN == 0);
    conv_enc_core u_core (
        .state(s),
        .u(u),
        .next_state(s_nxt),
        .c0(c0),
        .c1(c1)
    );
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st <= IDLE;
            s <= 2'b00;
            sym_valid_o <= 1'b0;
            sym_o <= 2'b00;
            sym_last_o <= 1'b0;
            busy_o <= 1'b0;
            sym_cnt_o <= '0;
            clr_pend <= 1'b0;
        end else begin
            if (accept || tail_step) begin
                s <= frame_end ? 2'b00 : s_nxt;
                sym_o <= {c0, c1};
                sym_valid_o <= 1'b1;
                sym_last_o <= frame_end;
            end else if (sym_ready_i) begin
                sym_valid_o <= 1'b0;
                sym_last_o <= 1'b0;
            end
            st <= accept ? (in_last_i ? (TAIL_EN != 0 ? TAIL1 : IDLE) : DATA)
                : tail_step ? (st == TAIL1 ? TAIL2 : IDLE) : st;
            busy_o <= accept || (busy_o && !(cons && sym_last_o));
            // the final count stays visible for one cycle before clearing
            clr_pend <= cons && sym_last_o;
            sym_cnt_o <= (clr_pend ? '0 : sym_cnt_o) + CNT_W'(cons);
        end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: checks conv_encoder (with and without tail) against a bit-history convolution model plus literal vectors
module tb_conv_encoder;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] in_valid, in_bit, in_last, in_ready, sym_valid, sym_last, sym_ready, busy;
    logic [1:0] sym [2];
    logic [15:0] cnt [2];
    int errors = 0;
    int checks = 0;
    logic [2:0] expq [2][$];
    logic [2:0] log_q [2][$];
    logic [1:0] h1, h2, clr, mbusy, mvalid, held;
    logic [2:0] hold_v [2];
    int tail [2];
    int mcnt [2];
    int cmax [2];
    bit bp_on;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        conv_encoder #(.TAIL_EN(g), .CNT_W(16)) dut (
            .clk_i(clk),
            .rst_n_i(rst_n),
            .in_valid_i(in_valid[g]),
            .in_bit_i(in_bit[g]),
            .in_last_i(in_last[g]),
            .in_ready_o(in_ready[g]),
            .sym_valid_o(sym_valid[g]),
            .sym_o(sym[g]),
            .sym_last_o(sym_last[g]),
            .sym_ready_i(sym_ready[g]),
            .busy_o(busy[g]),
            .sym_cnt_o(cnt[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // model: c0 = u^u[-1]^u[-2], c1 = u^u[-2] over the frame's bit history
    task automatic push_bit(input int g, input logic u, input logic last);
        expq[g].push_back({u ^ h1[g] ^ h2[g], u ^ h2[g], last});
        h2[g] = h1[g];
        h1[g] = u;
    endtask

    task automatic monitor();
        logic [2:0] e;
        logic acc, cons, ld, tl;
        int nc;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!rst_n) begin
                    expq[g].delete();
                    h1[g] = 0; h2[g] = 0; clr[g] = 0; mbusy[g] = 0; mvalid[g] = 0; held[g] = 0;
                    tail[g] = 0; mcnt[g] = 0;
                    check("reset_outputs", 32'({sym_valid[g], sym[g], sym_last[g], busy[g], cnt[g], in_ready[g]}), 32'h1);
                    continue;
                end
                ld = !mvalid[g] || sym_ready[g];
                check("in_ready", 32'(in_ready[g]), 32'(ld && tail[g] == 0));
                check("sym_valid", 32'(sym_valid[g]), 32'(mvalid[g]));
                if (held[g]) check("hold", 32'({sym[g], sym_last[g]}), 32'(hold_v[g]));
                check("busy", 32'(busy[g]), 32'(mbusy[g]));
                check("sym_cnt", 32'(cnt[g]), 32'(mcnt[g] % 65536));
                if (int'(cnt[g]) > cmax[g]) cmax[g] = int'(cnt[g]);
                acc = in_valid[g] && in_ready[g];
                cons = sym_valid[g] && sym_ready[g];
                e = 3'b000;
                if (cons) begin
                    check("sym_expected", 32'(expq[g].size() != 0), 32'(1));
                    if (expq[g].size() != 0) e = expq[g].pop_front();
                    check("sym", 32'({sym[g], sym_last[g]}), 32'(e));
                    log_q[g].push_back({sym[g], sym_last[g]});
                end
                nc = clr[g] ? 0 : mcnt[g];
                mcnt[g] = cons ? nc + 1 : nc;
                clr[g] = cons && e[0];
                mbusy[g] = acc || (mbusy[g] && !(cons && e[0]));
                held[g] = sym_valid[g] && !sym_ready[g];
                hold_v[g] = {sym[g], sym_last[g]};
                tl = tail[g] != 0 && ld;
                if (tl) tail[g]--;
                mvalid[g] = acc || tl || (mvalid[g] && !sym_ready[g]);
                if (acc) begin
                    push_bit(g, in_bit[g], g == 0 && in_last[g]);
                    if (in_last[g]) begin
                        if (g == 1) begin
                            push_bit(1, 1'b0, 1'b0);
                            push_bit(1, 1'b0, 1'b1);
                            tail[g] = 2;
                        end
                        h1[g] = 0;
                        h2[g] = 0;
                    end
                end
            end
        end
    endtask

    task automatic bp_drive();
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) sym_ready = 2'($urandom_range(0, 3));
        end
    endtask

    // called at posedge+1; returns at posedge+1 after the bit was accepted
    task automatic send_bit(input int g, input logic b, input logic l, output int w);
        w = 0;
        in_valid[g] = 1'b1;
        in_bit[g] = b;
        in_last[g] = l;
        do begin
            @(negedge clk);
            w++;
        end while (!in_ready[g] && w < 100);
        if (!in_ready[g]) check("accept_timeout", 32'(w), 32'(0));
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
        in_bit[g] = 1'b1;
        in_last[g] = 1'b1;
    endtask

    task automatic send(input int g, input logic [31:0] bits, input int n);
        int w;
        for (int i = 0; i < n; i++) send_bit(g, bits[i], i == n - 1, w);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy != 0 || mvalid != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", 32'(busy | mvalid), 32'(0));
        check("queue_empty", 32'(expq[0].size() + expq[1].size()), 32'(0));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input int g, input string name, input logic [2:0] want [$]);
        check({name, "_len"}, 32'(log_q[g].size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < log_q[g].size(); i++)
            check(name, 32'(log_q[g][i]), 32'(want[i]));
    endtask

    task automatic rand_frames(input int g);
        int w;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
            send_bit(g, 1'($urandom_range(0, 1)), i == 999 || $urandom_range(0, 15) == 0, w);
        end
    endtask

    initial begin
        logic [2:0] want [$];
        int w;
        rst_n = 1'b0;
        in_valid = 2'b00;
        in_bit = 2'b00;
        in_last = 2'b00;
        sym_ready = 2'b11;
        bp_on = 1'b0;
        fork
            monitor();
            bp_drive();
            begin
                #1000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none
        #12;
        for (int g = 0; g < 2; g++)
            check("reset_state", 32'({sym_valid[g], sym[g], sym_last[g], busy[g], cnt[g], in_ready[g]}), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // tailed frame 1,0,1,1
        cmax[1] = 0;
        send(1, 32'b1101, 4);
        drain();
        want = '{3'b110, 3'b100, 3'b000, 3'b010, 3'b010, 3'b111};
        check_log(1, "tail_frame", want);
        check("cnt_peak", 32'(cmax[1]), 32'(6));
        check("cnt_cleared", 32'(cnt[1]), 32'(0));

        // untailed frame 1,0,1,1 then a single-bit frame 1
        send(0, 32'b1101, 4);
        send(0, 32'b1, 1);
        drain();
        want = '{3'b110, 3'b100, 3'b000, 3'b011, 3'b111};
        check_log(0, "notail_frame", want);

        // three-cycle output stall mid-frame
        log_q[1].delete();
        fork
            begin
                repeat (2) @(posedge clk);
                #1 sym_ready[1] = 1'b0;
                @(negedge clk);
                check("stall_in_ready", 32'(in_ready[1]), 32'(0));
                check("stall_sym_valid", 32'(sym_valid[1]), 32'(1));
                repeat (3) @(posedge clk);
                #1 sym_ready[1] = 1'b1;
            end
        join_none
        send(1, 32'b1101, 4);
        drain();
        want = '{3'b110, 3'b100, 3'b000, 3'b010, 3'b010, 3'b111};
        check_log(1, "stall_frame", want);

        // next frame's bit held valid through the tail
        log_q[1].delete();
        send(1, 32'b01, 2);
        send_bit(1, 1'b1, 1'b1, w);
        check("held_bit_wait", 32'(w), 32'(3));
        drain();
        want = '{3'b110, 3'b100, 3'b110, 3'b001, 3'b110, 3'b100, 3'b111};
        check_log(1, "held_frame", want);

        // asynchronous reset mid-frame
        send_bit(1, 1'b1, 1'b0, w);
        send_bit(1, 1'b0, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++)
            check("async_reset", 32'({sym_valid[g], sym[g], sym_last[g], busy[g], cnt[g], in_ready[g]}), 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        log_q[1].delete();
        send(1, 32'b1, 1);
        drain();
        want = '{3'b110, 3'b100, 3'b111};
        check_log(1, "after_reset", want);

        // random frames with random backpressure on both variants
        bp_on = 1'b1;
        fork
            rand_frames(0);
            rand_frames(1);
        join
        bp_on = 1'b0;
        sym_ready = 2'b11;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
